string_fetch_master: RTL
========================

# string_fetch_master

Avalon-MM master that fetches a null-terminated string from system memory into a local word buffer and reports its byte length. It is the initiator-side counterpart of the string register slave on the same fabric. Software or the string accelerator control logic supplies a base address and word limit; this block issues word reads, scans each word for a 0x00 byte, and stops at the terminator or the limit.

## Interface
Parameters:
- MAX_WORDS, 8, capacity of the local buffer in 32-bit words
- LEN_W, $clog2(4*MAX_WORDS+1), width of the byte-length result

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  32  byte address of the first word; bits [1:0] are ignored (forced to 0)
- max_words  in  $clog2(MAX_WORDS+1)  word limit; values above MAX_WORDS clamp to MAX_WORDS
- busy  out  1  high in REQ and WAIT_DATA
- done  out  1  one-cycle pulse in DONE
- length  out  LEN_W  bytes before the first null; valid from done until the next accepted start
- truncated  out  1  limit reached with no null found; valid with length
- rd_index  in  $clog2(MAX_WORDS)  buffer read index
- rd_word  out  32  combinational buffer[rd_index]
- avm_address  out  32  word-aligned read address
- avm_read  out  1  read command
- avm_byteenable  out  4  constant 4'hF
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data valid

## Operation
- States are IDLE, REQ, WAIT_DATA and DONE.
- IDLE:
  - On start, latch the aligned base address and the clamped limit, clear the word count, and enter REQ.
  - If the clamped limit is 0, enter DONE directly with length 0 and truncated 0.
- REQ:
  - Drive avm_read=1 and avm_address = base + 4*count.
  - While waitrequest=1, hold address and read stable.
  - On the first cycle with waitrequest=0 the command is accepted; enter WAIT_DATA.
- WAIT_DATA:
  - avm_read=0; exactly one read is outstanding.
  - On readdatavalid, write readdata to buffer[count] and increment count.
  - Scan bytes little-endian, byte 0 = readdata[7:0] first.
  - If a null is found at byte k: length = 4*(count before increment) + k, truncated=0, go to DONE.
  - Else if the incremented count equals the limit: length = 4*limit, truncated=1, go to DONE.
  - Otherwise return to REQ.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored when the state is not IDLE.
- readdatavalid is ignored outside WAIT_DATA.
- Buffer words beyond the fetched count keep their previous contents.
- Async reset values:
  - State goes to IDLE.
  - avm_read=0, avm_address=0.
  - busy=0, done=0, length=0, truncated=0.
  - count=0 and all buffer words 0.
  - Reset mid-transfer abandons the outstanding read; the slave's late readdatavalid is ignored.

## Timing
- start is sampled at edge 0. REQ is active in cycle 1.
- With waitrequest=0 and read latency L (readdatavalid L≥1 cycles after acceptance), each word costs 1+L cycles.
- done asserts the cycle after the final readdatavalid.
- Example: n words, L=1, no stalls: done in cycle 2n+1.
- Each waitrequest stall cycle adds one cycle.
- length and truncated update on the same edge that enters DONE.
- rd_word has no latency.

## Structure
- Package string_hw_pkg holds:
  - the fetch_state_t enum {IDLE, REQ, WAIT_DATA, DONE}
  - MAX_WORDS_DEFAULT
  - function first_null(input [31:0] w) returning {found, idx[1:0]}
- Sub-module string_null_detect is a combinational byte scanner wrapping first_null. It is instantiated once on avm_readdata.

## Test plan
- "Hi" at 0x1000: readdata 32'h00006948, L=1, max_words=8. Expect one read at 0x1000, length=2, truncated=0, done in cycle 3, rd_word[0]=32'h00006948.
- Eight words with no null, base 0x1002, max_words=8. Expect reads at 0x1000..0x101C in order, length=32, truncated=1, exactly 8 avm_read acceptances.
- waitrequest held 3 cycles on word 1. Expect avm_address=0x1004 and avm_read stable for 4 cycles, a single acceptance, and done delayed by 3 cycles.
- Null in readdata[7:0] of word 3 (words 0-2 non-null). Expect 4 reads, length=12, truncated=0.
- reset_n low during WAIT_DATA, then a late readdatavalid:
  - Expect avm_read=0, busy=0 and buffer cleared immediately.
  - The late readdatavalid causes no capture.
  - A subsequent start fetches normally.
- max_words=0. Expect done in cycle 1, length=0, no avm_read. Separately, a start pulse issued mid-transfer has no effect.

Source files
------------

// File: rtl/string_fetch_master_pkg.sv
// Shared types and helpers for the string fetch master: FSM state encoding,
// default buffer depth and the little-endian first-null byte scanner.
package string_hw_pkg;

    localparam int MAX_WORDS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } fetch_state_t;

    // Returns {found, idx}; byte 0 (w[7:0]) has priority, so scan downward and let lower bytes win.
    function automatic logic [2:0] first_null(input logic [31:0] w);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (w[8*i +: 8] == 8'h00) begin
                res = {1'b1, 2'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/string_fetch_master_if.sv
// Avalon-MM read-only master bundle used by the string fetch master.
interface string_fetch_master_if;

    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        output avm_byteenable,
        input  avm_readdata,
        input  avm_waitrequest,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_byteenable,
        output avm_readdata,
        output avm_waitrequest,
        output avm_readdatavalid
    );

endinterface

// File: rtl/string_fetch_master_null_detect.sv
// Combinational byte scanner: flags the lowest-addressed 0x00 byte of a word.
module string_null_detect
    import string_hw_pkg::*;
(
    input  logic [31:0] word,
    output logic        found,
    output logic [1:0]  idx
);

    logic [2:0] res_s;

    assign res_s        = first_null(word);
    assign {found, idx} = res_s;

endmodule

// File: rtl/string_fetch_master.sv
// Avalon-MM master fetching a null-terminated string into a local word buffer
// and reporting its byte length (or truncation at the word limit).
module string_fetch_master
    import string_hw_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter int LEN_W     = $clog2(4*MAX_WORDS+1)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [31:0]                      base_addr,
    input  logic [$clog2(MAX_WORDS+1)-1:0]   max_words,
    output logic                             busy,
    output logic                             done,
    output logic [LEN_W-1:0]                 length,
    output logic                             truncated,
    input  logic [$clog2(MAX_WORDS)-1:0]     rd_index,
    output logic [31:0]                      rd_word,
    string_fetch_master_if.master            avm
);

    localparam int CNT_W = $clog2(MAX_WORDS+1);
    localparam int IDX_W = $clog2(MAX_WORDS);

    fetch_state_t      state_r, state_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic [CNT_W-1:0]  limit_r, limit_s;
    logic [CNT_W-1:0]  limit_clamp_s;
    logic [31:0]       base_r, base_s;
    logic [LEN_W-1:0]  length_r, length_s;
    logic              trunc_r, trunc_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              read_r, read_s;
    logic [31:0]       addr_r, addr_s;
    logic              buf_we_s;
    logic [31:0]       buf_r [MAX_WORDS];
    logic              null_found_s;
    logic [1:0]        null_idx_s;

    string_null_detect u_null_detect (
        .word  (avm.avm_readdata),
        .found (null_found_s),
        .idx   (null_idx_s)
    );

    // Word limit saturates at the buffer capacity.
    always_comb begin
        if (max_words > CNT_W'(MAX_WORDS)) begin
            limit_clamp_s = CNT_W'(MAX_WORDS);
        end else begin
            limit_clamp_s = max_words;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        limit_s  = limit_r;
        base_s   = base_r;
        length_s = length_r;
        trunc_s  = trunc_r;
        buf_we_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    base_s   = base_addr & 32'hFFFF_FFFC;
                    limit_s  = limit_clamp_s;
                    count_s  = {CNT_W{1'b0}};
                    length_s = {LEN_W{1'b0}};
                    trunc_s  = 1'b0;
                    if (limit_clamp_s == {CNT_W{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (!avm.avm_waitrequest) begin
                    state_s = WAIT_DATA;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT_DATA: begin
                if (avm.avm_readdatavalid) begin
                    buf_we_s = 1'b1;
                    count_s  = count_r + CNT_W'(1);
                    if (null_found_s) begin
                        length_s = LEN_W'({count_r, 2'b00}) + LEN_W'(null_idx_s);
                        trunc_s  = 1'b0;
                        state_s  = DONE;
                    end else if (count_s == limit_r) begin
                        length_s = LEN_W'({limit_r, 2'b00});
                        trunc_s  = 1'b1;
                        state_s  = DONE;
                    end else begin
                        state_s = REQ;
                    end
                end else begin
                    state_s = WAIT_DATA;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s == REQ) || (state_s == WAIT_DATA);
        done_s = (state_s == DONE);
        read_s = (state_s == REQ);
        if (state_s == REQ) begin
            addr_s = base_s + 32'({count_s, 2'b00});
        end else begin
            addr_s = addr_r;
        end
    end

    // State, control and registered output updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            count_r  <= {CNT_W{1'b0}};
            limit_r  <= {CNT_W{1'b0}};
            base_r   <= 32'h0000_0000;
            length_r <= {LEN_W{1'b0}};
            trunc_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            read_r   <= 1'b0;
            addr_r   <= 32'h0000_0000;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            limit_r  <= limit_s;
            base_r   <= base_s;
            length_r <= length_s;
            trunc_r  <= trunc_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            read_r   <= read_s;
            addr_r   <= addr_s;
        end
    end

    // Local word buffer; unfetched words keep their previous contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_WORDS; i++) begin
                buf_r[i] <= 32'h0000_0000;
            end
        end else if (buf_we_s) begin
            buf_r[count_r[IDX_W-1:0]] <= avm.avm_readdata;
        end
    end

    assign busy               = busy_r;
    assign done               = done_r;
    assign length             = length_r;
    assign truncated          = trunc_r;
    assign rd_word            = buf_r[rd_index];
    assign avm.avm_address    = addr_r;
    assign avm.avm_read       = read_r;
    assign avm.avm_byteenable = 4'hF;

endmodule
